// File: rtl/uart_cmd_regs.sv
// Framed serial command parser: HEADER, address, DATA_BYTES payload, checksum.
// Writes a register bank and answers each frame with an ACK/NAK byte.
module uart_cmd_regs #(
   parameter int                      NUM_REGS    = 4,
   parameter int                      DATA_BYTES  = 1,
   parameter logic [7:0]              HEADER      = 8'h55,
   parameter logic [7:0]              ACK_BYTE    = 8'hAA,
   parameter logic [7:0]              NAK_BYTE    = 8'hEE,
   parameter int                      TIMEOUT_CYC = 500000,
   parameter logic [8*DATA_BYTES-1:0] RESET_VAL   = '0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic [7:0]                         rx_data,
   input  logic                               rx_valid,
   output logic [7:0]                         tx_data,
   output logic                               tx_valid,
   input  logic                               tx_ready,
   output logic [NUM_REGS*8*DATA_BYTES-1:0]   regs_o,
   output logic                               upd_pulse,
   output logic [3:0]                         upd_idx,
   output logic [7:0]                         err_cnt
);

   localparam int REG_W = 8 * DATA_BYTES;
   localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] ADDR = 2'd1;
   localparam logic [1:0] DATA = 2'd2;
   localparam logic [1:0] CSUM = 2'd3;

   logic [1:0]       state_q, state_d;
   logic [2:0]       byteCnt_q, byteCnt_d;
   logic [TO_W-1:0]  toCnt_q, toCnt_d;
   logic [7:0]       csum_q, csum_d;
   logic [7:0]       addr_q, addr_d;
   logic [REG_W-1:0] shift_q, shift_d;
   logic [REG_W-1:0] regs_q [NUM_REGS];
   logic [7:0]       txData_q;
   logic             txValid_q;
   logic             updPulse_q;
   logic [3:0]       updIdx_q;
   logic [7:0]       errCnt_q;

   logic             doWrite;
   logic             respond;
   logic [7:0]       respByte;
   logic             errInc;

   // Parser next-state; the timeout counter only runs while inside a frame.
   always_comb begin
      state_d   = state_q;
      byteCnt_d = byteCnt_q;
      toCnt_d   = toCnt_q;
      csum_d    = csum_q;
      addr_d    = addr_q;
      shift_d   = shift_q;
      doWrite   = 1'b0;
      respond   = 1'b0;
      respByte  = ACK_BYTE;
      errInc    = 1'b0;
      if (state_q == IDLE) begin
         toCnt_d = '0;
         if (rx_valid && rx_data == HEADER) begin
            state_d = ADDR;
            csum_d  = 8'h00;
         end
      end else if (rx_valid) begin
         toCnt_d = '0;
         if (state_q == ADDR) begin
            addr_d    = rx_data;
            csum_d    = csum_q + rx_data;
            byteCnt_d = 3'd0;
            state_d   = DATA;
         end else if (state_q == DATA) begin
            shift_d = REG_W'({shift_q, rx_data});
            csum_d  = csum_q + rx_data;
            if (byteCnt_q == 3'(DATA_BYTES - 1)) begin
               state_d = CSUM;
            end else begin
               byteCnt_d = byteCnt_q + 3'd1;
            end
         end else begin
            state_d = IDLE;
            respond = 1'b1;
            if (rx_data == csum_q && addr_q < 8'(NUM_REGS)) begin
               doWrite = 1'b1;
            end else begin
               respByte = NAK_BYTE;
               errInc   = 1'b1;
            end
         end
      end else if (toCnt_q == TO_LAST) begin
         state_d = IDLE;
         toCnt_d = '0;
         errInc  = 1'b1;
      end else begin
         toCnt_d = toCnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         byteCnt_q  <= '0;
         toCnt_q    <= '0;
         csum_q     <= '0;
         addr_q     <= '0;
         shift_q    <= '0;
         txData_q   <= '0;
         txValid_q  <= 1'b0;
         updPulse_q <= 1'b0;
         updIdx_q   <= '0;
         errCnt_q   <= '0;
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= RESET_VAL;
         end
      end else begin
         state_q    <= state_d;
         byteCnt_q  <= byteCnt_d;
         toCnt_q    <= toCnt_d;
         csum_q     <= csum_d;
         addr_q     <= addr_d;
         shift_q    <= shift_d;
         updPulse_q <= doWrite;
         if (doWrite) begin
            updIdx_q <= addr_q[3:0];
         end
         for (int i = 0; i < NUM_REGS; i++) begin
            if (doWrite && addr_q == 8'(i)) begin
               regs_q[i] <= shift_q;
            end
         end
         // A fresh response always wins over a pending or just-accepted one.
         if (respond) begin
            txData_q  <= respByte;
            txValid_q <= 1'b1;
         end else if (txValid_q && tx_ready) begin
            txValid_q <= 1'b0;
         end
         if (errInc && errCnt_q != 8'hFF) begin
            errCnt_q <= errCnt_q + 8'd1;
         end
      end
   end

   always_comb begin
      regs_o = '0;
      for (int i = 0; i < NUM_REGS; i++) begin
         regs_o[i*REG_W +: REG_W] = regs_q[i];
      end
   end

   assign tx_data   = txData_q;
   assign tx_valid  = txValid_q;
   assign upd_pulse = updPulse_q;
   assign upd_idx   = updIdx_q;
   assign err_cnt   = errCnt_q;

endmodule

// File: tb/tb_uart_cmd_regs.sv
// Bench for uart_cmd_regs: two instances (1- and 2-byte payload) share one rx stream
// and are compared every cycle against a frame-level reference model.
module tb_uart_cmd_regs;

   localparam int NREG = 4;
   localparam int TO   = 40;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [7:0]  rxData = 8'h00;
   logic        rxValid = 1'b0;
   logic        txReady = 1'b0;

   logic [7:0]  txData1, txData2;
   logic        txValid1, txValid2;
   logic [31:0] regs1;
   logic [63:0] regs2;
   logic        upd1, upd2;
   logic [3:0]  idx1, idx2;
   logic [7:0]  err1, err2;

   int checks = 0;
   int errors = 0;
   bit randomReady = 1'b0;
   bit fixedReady = 1'b0;

   // Reference model state, one slot per instance (slot k has k+1 payload bytes).
   bit          mCollect [2];
   logic [7:0]  mBuf [2][8];
   int          mCnt [2];
   int          mIdle [2];
   logic [31:0] mRegs [2][NREG];
   bit          mTxValid [2];
   logic [7:0]  mTxData [2];
   bit          mUpd [2];
   logic [3:0]  mIdx [2];
   int          mErr [2];

   always #5 clk = ~clk;

   uart_cmd_regs #(
      .NUM_REGS(NREG), .DATA_BYTES(1), .TIMEOUT_CYC(TO)
   ) dut1 (
      .clk(clk), .rst(rst), .rx_data(rxData), .rx_valid(rxValid),
      .tx_data(txData1), .tx_valid(txValid1), .tx_ready(txReady),
      .regs_o(regs1), .upd_pulse(upd1), .upd_idx(idx1), .err_cnt(err1)
   );

   uart_cmd_regs #(
      .NUM_REGS(NREG), .DATA_BYTES(2), .TIMEOUT_CYC(TO)
   ) dut2 (
      .clk(clk), .rst(rst), .rx_data(rxData), .rx_valid(rxValid),
      .tx_data(txData2), .tx_valid(txValid2), .tx_ready(txReady),
      .regs_o(regs2), .upd_pulse(upd2), .upd_idx(idx2), .err_cnt(err2)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      if (observed !== expected) begin
         errors++;
         $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic modelReset();
      for (int k = 0; k < 2; k++) begin
         mCollect[k] = 1'b0;
         mCnt[k]     = 0;
         mIdle[k]    = 0;
         mTxValid[k] = 1'b0;
         mTxData[k]  = 8'h00;
         mUpd[k]     = 1'b0;
         mIdx[k]     = 4'h0;
         mErr[k]     = 0;
         for (int i = 0; i < NREG; i++) mRegs[k][i] = 32'h0;
      end
   endtask

   // One clock edge of the reference model for instance k.
   task automatic modelStep(input int k, input logic v, input logic [7:0] d, input logic rdy);
      int db;
      bit newResp;
      logic [7:0] rb;
      logic [7:0] sum;
      logic [31:0] val;
      db = k + 1;
      newResp = 1'b0;
      rb = 8'h00;
      mUpd[k] = 1'b0;
      if (!mCollect[k]) begin
         if (v && d == 8'h55) begin
            mCollect[k] = 1'b1;
            mCnt[k] = 0;
            mIdle[k] = 0;
         end
      end else if (v) begin
         mIdle[k] = 0;
         mBuf[k][mCnt[k]] = d;
         mCnt[k]++;
         if (mCnt[k] == db + 2) begin
            sum = 8'h00;
            val = 32'h0;
            for (int i = 0; i <= db; i++) sum = sum + mBuf[k][i];
            for (int i = 1; i <= db; i++) val = (val << 8) | 32'(mBuf[k][i]);
            newResp = 1'b1;
            if (sum == mBuf[k][db+1] && int'(mBuf[k][0]) < NREG) begin
               mRegs[k][mBuf[k][0]] = val;
               mUpd[k] = 1'b1;
               mIdx[k] = mBuf[k][0][3:0];
               rb = 8'hAA;
            end else begin
               rb = 8'hEE;
               if (mErr[k] < 255) mErr[k]++;
            end
            mCollect[k] = 1'b0;
         end
      end else begin
         mIdle[k]++;
         if (mIdle[k] == TO) begin
            mCollect[k] = 1'b0;
            if (mErr[k] < 255) mErr[k]++;
         end
      end
      if (newResp) begin
         mTxValid[k] = 1'b1;
         mTxData[k] = rb;
      end else if (mTxValid[k] && rdy) begin
         mTxValid[k] = 1'b0;
      end
   endtask

   task automatic checkAll();
      for (int k = 0; k < 2; k++) begin
         logic tv, up;
         logic [7:0] td, ec;
         logic [3:0] ix;
         tv = (k == 0) ? txValid1 : txValid2;
         td = (k == 0) ? txData1 : txData2;
         up = (k == 0) ? upd1 : upd2;
         ix = (k == 0) ? idx1 : idx2;
         ec = (k == 0) ? err1 : err2;
         checkOutput($sformatf("tx_valid_db%0d", k + 1), 32'(tv), 32'(mTxValid[k]));
         if (mTxValid[k]) checkOutput($sformatf("tx_data_db%0d", k + 1), 32'(td), 32'(mTxData[k]));
         checkOutput($sformatf("upd_pulse_db%0d", k + 1), 32'(up), 32'(mUpd[k]));
         if (mUpd[k]) checkOutput($sformatf("upd_idx_db%0d", k + 1), 32'(ix), 32'(mIdx[k]));
         checkOutput($sformatf("err_cnt_db%0d", k + 1), 32'(ec), 32'(mErr[k]));
         for (int i = 0; i < NREG; i++) begin
            logic [31:0] r;
            r = (k == 0) ? 32'(regs1[i*8 +: 8]) : 32'(regs2[i*16 +: 16]);
            checkOutput($sformatf("reg%0d_db%0d", i, k + 1), r, mRegs[k][i]);
         end
      end
   endtask

   // Drives one cycle of rx/tx_ready, advances the model on the edge, checks 1 ns later.
   task automatic applyStimulus(input logic v, input logic [7:0] d);
      logic rdy;
      rdy = randomReady ? ($urandom_range(0, 2) == 0) : fixedReady;
      rxValid = v;
      rxData  = d;
      txReady = rdy;
      @(posedge clk);
      modelStep(0, v, d, rdy);
      modelStep(1, v, d, rdy);
      #1;
      rxValid = 1'b0;
      checkAll();
   endtask

   task automatic sendByte(input logic [7:0] d);
      applyStimulus(1'b1, d);
   endtask

   task automatic idle(input int n);
      repeat (n) applyStimulus(1'b0, 8'h00);
   endtask

   task automatic doReset();
      rst = 1'b1;
      rxValid = 1'b0;
      #2;
      modelReset();
      checkAll();
      checkOutput("reset_tx_data_db1", 32'(txData1), 32'h0);
      checkOutput("reset_upd_idx_db1", 32'(idx1), 32'h0);
      @(posedge clk);
      #1;
      checkAll();
      rst = 1'b0;
   endtask

   task automatic randomFrame();
      int kind, db, gapMax;
      logic [7:0] addr, sum, b;
      kind = $urandom_range(0, 9);
      gapMax = $urandom_range(0, 3);
      if (kind == 0) begin
         sendByte(8'($urandom_range(0, 255)));
      end else if (kind == 1) begin
         idle($urandom_range(TO - 2, TO + 1));
      end else begin
         db = $urandom_range(1, 2);
         addr = (kind == 2) ? 8'($urandom_range(4, 255)) : 8'($urandom_range(0, 3));
         sendByte(8'h55);
         idle($urandom_range(0, gapMax));
         sendByte(addr);
         sum = addr;
         for (int i = 0; i < db; i++) begin
            b = 8'($urandom_range(0, 255));
            sum = sum + b;
            idle($urandom_range(0, gapMax));
            sendByte(b);
         end
         idle($urandom_range(0, gapMax));
         sendByte((kind == 3) ? sum + 8'h01 : sum);
      end
   endtask

   initial begin
      modelReset();
      doReset();

      // Basic write to reg2, response held while tx_ready is low.
      fixedReady = 1'b0;
      sendByte(8'h55); sendByte(8'h02); sendByte(8'h7F); sendByte(8'h81);
      idle(3);
      checkOutput("plan_reg2", 32'(regs1[23:16]), 32'h7F);
      checkOutput("plan_ack", 32'(txData1), 32'hAA);
      checkOutput("plan_ack_held", 32'(txValid1), 32'h1);
      fixedReady = 1'b1;
      idle(2);
      fixedReady = 1'b0;

      // Bad checksum, then bad address.
      sendByte(8'h55); sendByte(8'h01); sendByte(8'h10); sendByte(8'h00);
      idle(1);
      sendByte(8'h55); sendByte(8'h05); sendByte(8'h11); sendByte(8'h16);
      idle(1);
      checkOutput("plan_nak", 32'(txData1), 32'hEE);
      checkOutput("plan_err2", 32'(err1), 32'h2);
      fixedReady = 1'b1;
      idle(2);
      fixedReady = 1'b0;

      // Timeout resync, then a good frame to reg3.
      sendByte(8'h55); sendByte(8'h01);
      idle(TO);
      sendByte(8'h55); sendByte(8'h03); sendByte(8'h20); sendByte(8'h23);
      idle(1);
      checkOutput("plan_reg3", 32'(regs1[31:24]), 32'h20);

      // Junk before header, two-byte payload frame.
      fixedReady = 1'b1;
      sendByte(8'h00); sendByte(8'hFF);
      sendByte(8'h55); sendByte(8'h00); sendByte(8'h12); sendByte(8'h34); sendByte(8'h46);
      idle(2);
      checkOutput("plan_reg0_db2", 32'(regs2[15:0]), 32'h1234);

      // Back-to-back responses with tx_ready low; newest result wins.
      fixedReady = 1'b0;
      sendByte(8'h55); sendByte(8'h00); sendByte(8'h11); sendByte(8'h11);
      sendByte(8'h55); sendByte(8'h01); sendByte(8'h22); sendByte(8'h23);
      idle(1);
      sendByte(8'h55); sendByte(8'h01); sendByte(8'h22); sendByte(8'h00);
      idle(1);
      checkOutput("plan_newest", 32'(txData1), 32'hEE);
      fixedReady = 1'b1;
      idle(1);
      fixedReady = 1'b0;
      idle(2);

      // Gap of TIMEOUT_CYC-1 cycles must not abort the frame.
      sendByte(8'h55); sendByte(8'h01);
      idle(TO - 1);
      sendByte(8'h33); sendByte(8'h34);
      idle(TO + 2);

      // Reset mid-frame discards the frame and the bank.
      sendByte(8'h55); sendByte(8'h02); sendByte(8'h7F);
      doReset();
      sendByte(8'h81);
      idle(3);
      checkOutput("plan_rst_reg2", 32'(regs1[23:16]), 32'h0);

      // Randomized traffic with random tx_ready.
      randomReady = 1'b1;
      for (int n = 0; n < 300; n++) randomFrame();
      idle(TO + 5);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_cmd_regs.md
Name: uart_cmd_regs

Overview:
- Parametrised, framed command parser that replaces the fixed 4-byte positional threshold loader on the serial debug path.
- Takes the received-byte stream from the UART receiver and decodes frames of the form header, address, data bytes, checksum.
- Writes a bank of NUM_REGS threshold/config registers, and sends an ACK or NAK byte back through the UART transmitter.
- A mid-frame inactivity timeout resynchronises the parser, so one lost byte cannot permanently shift register assignment.

Parameters:
- NUM_REGS, 4: number of registers in the bank (1..16).
- DATA_BYTES, 1: payload bytes per register (1..4), sent big-endian; register width REG_W = 8*DATA_BYTES.
- HEADER, 8'h55: frame start byte.
- ACK_BYTE, 8'hAA: response to a frame that was accepted.
- NAK_BYTE, 8'hEE: response to a frame that was rejected.
- TIMEOUT_CYC, 500000: maximum clk cycles allowed between bytes inside a frame.
- RESET_VAL, 0: reset value of every register (REG_W bits).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous active-high reset.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe; rx_data is valid in that cycle.
- tx_data  out  8  response byte.
- tx_valid  out  1  response available; held until accepted.
- tx_ready  in  1  transmitter accepts tx_data when tx_valid && tx_ready.
- regs_o  out  NUM_REGS*REG_W  packed register bank; register i occupies bits [i*REG_W +: REG_W].
- upd_pulse  out  1  one-cycle strobe when a register is written.
- upd_idx  out  4  index of the register written; valid with upd_pulse.
- err_cnt  out  8  saturating count of rejected and timed-out frames.

Behaviour:
- Interface: one clock, clk. Reset rst is asynchronous and active-high.
- Reset values:
  - every register = RESET_VAL;
  - tx_valid = 0, tx_data = 0;
  - upd_pulse = 0, upd_idx = 0;
  - err_cnt = 0;
  - FSM in IDLE, byte counter = 0, timeout counter = 0, checksum accumulator = 0.
- FSM states:
  - IDLE:
    - rx_valid with rx_data == HEADER -> ADDR; clear checksum accumulator and timeout counter.
    - Any other byte is ignored, with no error count.
  - ADDR:
    - Byte is latched as the address and added to the checksum.
    - -> DATA with byte counter = 0.
  - DATA:
    - Each byte is shifted into the data shift register (first byte = MSB) and added to the checksum.
    - After DATA_BYTES bytes -> CSUM.
  - CSUM:
    - Received byte is compared against the checksum, the 8-bit modulo-256 sum of address and all data bytes.
    - Match and address < NUM_REGS: write the register, queue ACK_BYTE.
    - Otherwise: no write, queue NAK_BYTE, err_cnt += 1.
    - -> IDLE.
- Latency:
  - The register update, upd_pulse/upd_idx and tx_valid rise all occur in the cycle after the rx_valid that carries the checksum byte.
  - upd_pulse lasts exactly 1 cycle.
- Timeout:
  - In ADDR, DATA or CSUM, the timeout counter increments every cycle without rx_valid and clears on rx_valid.
  - Reaching TIMEOUT_CYC -> IDLE, err_cnt += 1, no response byte.
  - A HEADER byte arriving in a non-IDLE state is treated as data; only the timeout resynchronises the parser.
- Response handshake:
  - One-entry response buffer.
  - tx_valid stays high and tx_data stays stable until tx_ready is sampled high; tx_valid drops the cycle after acceptance.
  - A new response while one is still pending overwrites tx_data and keeps tx_valid high. The newest result wins.
  - A new response arriving in the same cycle as acceptance is loaded, and tx_valid stays high.
- err_cnt saturates at 8'hFF.
- Parsing is independent of the response handshake; the parser never stalls the rx stream.
- An address byte wider than 4 bits is still summed in full; any value >= NUM_REGS yields NAK.
- Reset asserted mid-frame aborts the frame: state, partial data and any pending response are discarded, and registers return to RESET_VAL.

Test Plan:
- NUM_REGS=4, DATA_BYTES=1: bytes 55 02 7F 81 -> regs_o[23:16]=8'h7F; upd_pulse for 1 cycle with upd_idx=2; tx_data=AA with tx_valid held until tx_ready; all other registers still 0.
- Bad checksum: 55 01 10 00 -> no register change, tx_data=EE, err_cnt=1. Then bad address 55 05 11 16 -> EE, err_cnt=2.
- Timeout resync: 55 01, then TIMEOUT_CYC idle cycles -> err_cnt=1 and no tx_valid. Then 55 03 20 23 -> reg3=8'h20, ACK.
- DATA_BYTES=2: 55 00 12 34 46 -> reg0=16'h1234, ACK. Leading junk bytes 00 FF before the header are ignored; err_cnt stays 0.
- Back-to-back responses with tx_ready held low: two valid frames (regs 0 and 1) -> both registers written, a single pending byte AA. Then the second frame is repeated with a bad checksum -> tx_data switches to EE. Raising tx_ready -> exactly one byte accepted.
- Reset mid-frame: 55 02 7F, then pulse rst, then 81 -> no write, no response, err_cnt=0. Earlier register contents are back at RESET_VAL.
